// File: rtl/z16_uart_pkg.sv
// Shared constants and types for the Z16 memory-mapped UART transmitter.
package z16_uart_pkg;

    localparam logic [15:0] UART_DATA_OFS = 16'd0;
    localparam logic [15:0] UART_STAT_OFS = 16'd2;

    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_ACTIVE_BIT = 2;
    localparam int STAT_OVF_BIT    = 3;
    localparam int STAT_COUNT_LSB  = 8;
    localparam int STAT_COUNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/z16_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and extended pointers.
module z16_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign o_count = wptr_q - rptr_q;
    assign o_rdata = mem_q[rptr_q[AW-1:0]];

    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (push_ok) begin
            mem_d[wptr_q[AW-1:0]] = i_wdata;
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/z16_uart_tx.sv
// Z16 bus-attached UART transmitter: register decode, status and 8N1 framer.
module z16_uart_tx
    import z16_uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] BASE_ADDR    = 16'hFF00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_we,
    input  logic        i_re,
    output logic [15:0] o_rdata,
    output logic        o_txd,
    output logic        o_busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          sel_data;
    logic          sel_stat;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_rdata;
    logic [15:0]   status;
    logic          tx_active;
    logic          bit_end;

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   rdata_q, rdata_d;

    logic unused_wdata;
    assign unused_wdata = ^{i_wdata[15:8], i_wdata[7:4], i_wdata[2:0]};

    assign sel_data = (i_addr == BASE_ADDR + UART_DATA_OFS);
    assign sel_stat = (i_addr == BASE_ADDR + UART_STAT_OFS);

    // Fullness is the registered value, so a same-cycle pop never admits a store.
    assign push = i_we && sel_data && !fifo_full;

    z16_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_wdata (i_wdata[7:0]),
        .i_pop   (pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign tx_active = (state_q != IDLE);
    assign o_busy    = tx_active || !fifo_empty;
    assign o_txd     = txd_q;
    assign o_rdata   = rdata_q;

    always_comb begin
        status = '0;
        status[STAT_FULL_BIT]   = fifo_full;
        status[STAT_EMPTY_BIT]  = fifo_empty;
        status[STAT_ACTIVE_BIT] = tx_active;
        status[STAT_OVF_BIT]    = ovf_q;
        status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        ovf_d = ovf_q;
        if (i_we && sel_stat && i_wdata[STAT_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (i_we && sel_data && fifo_full) begin
            ovf_d = 1'b1;
        end
        rdata_d = (i_re && sel_stat) ? status : 16'h0000;
    end

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state to keep o_txd glitch-free.
    always_comb begin
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
